// File: rtl/vmul_lane_sequencer_if.sv
// Handshake and data bundle for vmul_lane_sequencer: issue side, multiplier-lane side, writeback side.
// Build-wide width macros fall back to local defaults when the surrounding build does not define them.
`ifndef NUM_THREAD
`define NUM_THREAD 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif

interface vmul_lane_sequencer_if #(
    parameter int SOFT_THREAD = `NUM_THREAD,
    parameter int HARD_THREAD = 4,
    parameter int XLEN        = `XLEN,
    parameter int WID_W       = `DEPTH_WARP,
    parameter int IDX_W       = `REGIDX_WIDTH + `REGEXT_WIDTH
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [SOFT_THREAD*XLEN-1:0] in1_i;
    logic [SOFT_THREAD*XLEN-1:0] in2_i;
    logic [SOFT_THREAD*XLEN-1:0] in3_i;
    logic [SOFT_THREAD-1:0]      mask_i;
    logic [5:0]                  ctrl_alu_fn_i;
    logic                        ctrl_reverse_i;
    logic [WID_W-1:0]            ctrl_wid_i;
    logic [IDX_W-1:0]            ctrl_reg_idxw_i;
    logic                        ctrl_wvd_i;
    logic                        ctrl_wxd_i;

    logic                        mul_valid_o;
    logic                        mul_ready_i;
    logic [HARD_THREAD*XLEN-1:0] mul_in1_o;
    logic [HARD_THREAD*XLEN-1:0] mul_in2_o;
    logic [HARD_THREAD*XLEN-1:0] mul_in3_o;
    logic [HARD_THREAD-1:0]      mul_mask_o;
    logic [5:0]                  mul_alu_fn_o;
    logic                        mul_res_valid_i;
    logic                        mul_res_ready_o;
    logic [HARD_THREAD*XLEN-1:0] mul_res_i;

    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [SOFT_THREAD*XLEN-1:0] out_data_o;
    logic [SOFT_THREAD-1:0]      out_mask_o;
    logic [WID_W-1:0]            out_wid_o;
    logic [IDX_W-1:0]            out_reg_idxw_o;
    logic                        out_wvd_o;
    logic                        out_wxd_o;

    modport slave (
        input  in_valid_i, in1_i, in2_i, in3_i, mask_i, ctrl_alu_fn_i, ctrl_reverse_i,
               ctrl_wid_i, ctrl_reg_idxw_i, ctrl_wvd_i, ctrl_wxd_i,
               mul_ready_i, mul_res_valid_i, mul_res_i, out_ready_i,
        output in_ready_o, mul_valid_o, mul_in1_o, mul_in2_o, mul_in3_o, mul_mask_o,
               mul_alu_fn_o, mul_res_ready_o, out_valid_o, out_data_o, out_mask_o,
               out_wid_o, out_reg_idxw_o, out_wvd_o, out_wxd_o
    );

    modport master (
        output in_valid_i, in1_i, in2_i, in3_i, mask_i, ctrl_alu_fn_i, ctrl_reverse_i,
               ctrl_wid_i, ctrl_reg_idxw_i, ctrl_wvd_i, ctrl_wxd_i,
               mul_ready_i, mul_res_valid_i, mul_res_i, out_ready_i,
        input  in_ready_o, mul_valid_o, mul_in1_o, mul_in2_o, mul_in3_o, mul_mask_o,
               mul_alu_fn_o, mul_res_ready_o, out_valid_o, out_data_o, out_mask_o,
               out_wid_o, out_reg_idxw_o, out_wvd_o, out_wxd_o
    );
endinterface

// File: rtl/vmul_lane_sequencer.sv
// Splits one SOFT_THREAD-wide multiply into HARD_THREAD-wide beats and reassembles the writeback.
// Optional VMUL_SEQ_MASK_SKIP_EN: beats whose mask slice is all zero are skipped on issue and collect.
`ifndef NUM_THREAD
`define NUM_THREAD 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif

module vmul_lane_sequencer #(
    parameter int SOFT_THREAD = `NUM_THREAD,
    parameter int HARD_THREAD = 4,
    parameter int XLEN        = `XLEN,
    parameter int WID_W       = `DEPTH_WARP,
    parameter int IDX_W       = `REGIDX_WIDTH + `REGEXT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    vmul_lane_sequencer_if.slave bus
);
    localparam int BEATS  = SOFT_THREAD / HARD_THREAD;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int BEAT_W = HARD_THREAD * XLEN;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_iss;
    logic [CNT_W-1:0]            r_col;
    logic [SOFT_THREAD*XLEN-1:0] r_in1;
    logic [SOFT_THREAD*XLEN-1:0] r_in2;
    logic [SOFT_THREAD*XLEN-1:0] r_in3;
    logic [SOFT_THREAD*XLEN-1:0] r_res;
    logic [SOFT_THREAD-1:0]      r_mask;
    logic [5:0]                  r_fn;
    logic [WID_W-1:0]            r_wid;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_wvd;
    logic                        r_wxd;

    logic [BEATS-1:0]  w_act_in;
    logic [BEATS-1:0]  w_act_cap;
    logic [CNT_W-1:0]  w_first;
    logic [CNT_W-1:0]  w_iss_next;
    logic [CNT_W-1:0]  w_col_next;
    logic              w_iss_fire;
    logic              w_col_fire;
    logic [BEAT_W-1:0] w_beat_in1;
    logic [BEAT_W-1:0] w_beat_in2;
    logic [BEAT_W-1:0] w_beat_in3;
    logic [HARD_THREAD-1:0] w_beat_mask;

    // Smallest active beat index at or after start; BEATS when none remain.
    function automatic logic [CNT_W-1:0] next_beat(input logic [CNT_W-1:0] start,
                                                   input logic [BEATS-1:0] act);
        next_beat = BEATS_C;
        for (int b = BEATS - 1; b >= 0; b--)
            if ((CNT_W'(b) >= start) && act[b])
                next_beat = CNT_W'(b);
    endfunction

    always_comb begin
        w_act_in  = '1;
        w_act_cap = '1;
`ifdef VMUL_SEQ_MASK_SKIP_EN
        for (int b = 0; b < BEATS; b++) begin
            w_act_in[b]  = |bus.mask_i[b*HARD_THREAD +: HARD_THREAD];
            w_act_cap[b] = |r_mask[b*HARD_THREAD +: HARD_THREAD];
        end
`else
`endif
    end

    assign w_first    = next_beat('0, w_act_in);
    assign w_iss_next = next_beat(r_iss + 1'b1, w_act_cap);
    assign w_col_next = next_beat(r_col + 1'b1, w_act_cap);
    assign w_iss_fire = bus.mul_valid_o & bus.mul_ready_i;
    assign w_col_fire = bus.mul_res_valid_i & bus.mul_res_ready_o;

    always_comb begin
        w_beat_in1  = '0;
        w_beat_in2  = '0;
        w_beat_in3  = '0;
        w_beat_mask = '0;
        for (int b = 0; b < BEATS; b++)
            if (r_iss == CNT_W'(b)) begin
                w_beat_in1  = r_in1[b*BEAT_W +: BEAT_W];
                w_beat_in2  = r_in2[b*BEAT_W +: BEAT_W];
                w_beat_in3  = r_in3[b*BEAT_W +: BEAT_W];
                w_beat_mask = r_mask[b*HARD_THREAD +: HARD_THREAD];
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iss   <= '0;
            r_col   <= '0;
            r_in1   <= '0;
            r_in2   <= '0;
            r_in3   <= '0;
            r_res   <= '0;
            r_mask  <= '0;
            r_fn    <= '0;
            r_wid   <= '0;
            r_idx   <= '0;
            r_wvd   <= 1'b0;
            r_wxd   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        r_in1   <= bus.ctrl_reverse_i ? bus.in2_i : bus.in1_i;
                        r_in2   <= bus.ctrl_reverse_i ? bus.in1_i : bus.in2_i;
                        r_in3   <= bus.in3_i;
                        r_mask  <= bus.mask_i;
                        r_fn    <= bus.ctrl_alu_fn_i;
                        r_wid   <= bus.ctrl_wid_i;
                        r_idx   <= bus.ctrl_reg_idxw_i;
                        r_wvd   <= bus.ctrl_wvd_i;
                        r_wxd   <= bus.ctrl_wxd_i;
                        r_res   <= '0;
                        r_iss   <= w_first;
                        r_col   <= w_first;
                        // No active beat at all: nothing to issue, write back zeros directly.
                        r_state <= (w_first == BEATS_C) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_iss_fire)
                        r_iss <= w_iss_next;
                    if (w_col_fire) begin
                        for (int b = 0; b < BEATS; b++)
                            if (r_col == CNT_W'(b))
                                r_res[b*BEAT_W +: BEAT_W] <= bus.mul_res_i;
                        r_col <= w_col_next;
                        if (w_col_next == BEATS_C)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o      = (r_state == S_IDLE);
    assign bus.mul_valid_o     = (r_state == S_BUSY) && (r_iss < BEATS_C);
    assign bus.mul_res_ready_o = (r_state == S_BUSY) && (r_col < r_iss);
    assign bus.mul_in1_o       = w_beat_in1;
    assign bus.mul_in2_o       = w_beat_in2;
    assign bus.mul_in3_o       = w_beat_in3;
    assign bus.mul_mask_o      = w_beat_mask;
    assign bus.mul_alu_fn_o    = r_fn;
    assign bus.out_valid_o     = (r_state == S_DONE);
    assign bus.out_data_o      = r_res;
    assign bus.out_mask_o      = r_mask;
    assign bus.out_wid_o       = r_wid;
    assign bus.out_reg_idxw_o  = r_idx;
    assign bus.out_wvd_o       = r_wvd;
    assign bus.out_wxd_o       = r_wxd;
endmodule
